fwd_hazard_ctrl: RTL

Forwarding and hazard controller for the 16-bit MIPS pipeline's register-bank operand block. It tracks the destination register of every in-flight instruction across the EX, DM and WB stages. Each cycle it drives the A/B operand-select muxes (register file, ans_ex, ans_dm or ans_wb) and the immediate select for the instruction in decode. It detects load-use hazards, stalls decode for one cycle and inserts an EX bubble, and supplies the write address and enable presented to the register bank.

---
 rtl/fwd_hazard_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 16-bit MIPS pipeline.
// Tracks the destination register of the instructions in EX, DM and WB.
// Steers the A/B operand muxes, raises a one-cycle stall on load-use, and
// drives the register-bank write port from the WB-stage entry.
module fwd_hazard_ctrl #(
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  RA,
    input  logic [$clog2(NREG)-1:0]  RB,
    input  logic [$clog2(NREG)-1:0]  RW,
    input  logic                     use_A,
    input  logic                     use_B,
    input  logic                     imm_req,
    input  logic                     wr_req,
    input  logic                     is_load,
    input  logic                     flush,
    output logic [1:0]               mux_sel_A,
    output logic [1:0]               mux_sel_B,
    output logic                     imm_sel,
    output logic                     stall,
    output logic [$clog2(NREG)-1:0]  RW_dm,
    output logic                     wr_en,
    output logic [CNTW-1:0]          stall_cnt
);

    localparam int AW = $clog2(NREG);

    // Tracker entries: {valid, destination, is-load} per in-flight stage.
    logic          ex_valid_reg, dm_valid_reg, wb_valid_reg;
    logic [AW-1:0] ex_rw_reg, dm_rw_reg, wb_rw_reg;
    logic          ex_load_reg, dm_load_reg, wb_load_reg;
    logic [CNTW-1:0] stall_cnt_reg;

    logic dec_valid;

    // Per-source forwarding and hazard detection; index 0 is A, index 1 is B.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [AW-1:0] src;
            logic          used;
            logic          ex_hit, dm_hit, wb_hit;
            logic [1:0]    sel;
            logic          haz;

            assign src    = (gi == 0) ? RA : RB;
            assign used   = (gi == 0) ? use_A : (use_B & ~imm_req);
            assign ex_hit = ex_valid_reg && (ex_rw_reg == src);
            assign dm_hit = dm_valid_reg && (dm_rw_reg == src);
            assign wb_hit = wb_valid_reg && (wb_rw_reg == src);

            // Nearest producer wins; a load in EX cannot forward yet and
            // instead flags a hazard, letting DM/WB supply a fallback select.
            always_comb begin
                sel = 2'b00;
                haz = 1'b0;
                if (id_valid && used && (src != '0)) begin
                    haz = ex_hit & ex_load_reg;
                    if (ex_hit && !ex_load_reg)
                        sel = 2'b01;
                    else if (dm_hit)
                        sel = 2'b10;
                    else if (wb_hit)
                        sel = 2'b11;
                end
            end
        end
    endgenerate

    // A taken branch kills the decode slot, so it also suppresses the stall.
    assign stall     = id_valid & ~flush & (g_src[0].haz | g_src[1].haz);
    assign imm_sel   = id_valid & imm_req;
    assign mux_sel_A = g_src[0].sel;
    assign mux_sel_B = imm_sel ? 2'b00 : g_src[1].sel;

    // Register 0 is never tracked; stalled or flushed slots become bubbles.
    assign dec_valid = id_valid & wr_req & (RW != '0) & ~stall & ~flush;

    assign RW_dm     = wb_rw_reg;
    assign wr_en     = wb_valid_reg;
    assign stall_cnt = stall_cnt_reg;

    // Shift the tracker each cycle and count stall cycles with saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_rw_reg     <= '0;
            ex_load_reg   <= 1'b0;
            dm_valid_reg  <= 1'b0;
            dm_rw_reg     <= '0;
            dm_load_reg   <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_rw_reg     <= '0;
            wb_load_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            wb_valid_reg <= dm_valid_reg;
            wb_rw_reg    <= dm_rw_reg;
            wb_load_reg  <= dm_load_reg;
            if (flush) begin
                dm_valid_reg <= 1'b0;
                dm_rw_reg    <= '0;
                dm_load_reg  <= 1'b0;
            end else begin
                dm_valid_reg <= ex_valid_reg;
                dm_rw_reg    <= ex_rw_reg;
                dm_load_reg  <= ex_load_reg;
            end
            ex_valid_reg <= dec_valid;
            ex_rw_reg    <= RW;
            ex_load_reg  <= is_load;
            if (stall && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule
